// File: rtl/freq_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Holds the digit count, the scan FSM states and the segment codes.
package freq_pkg;

    localparam int NUM_DIGITOS = 5;

    typedef enum logic {
        APAGADO,
        ATIVO
    } estado_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0       = 7'h40;
    localparam logic [6:0] SEG_1       = 7'h79;
    localparam logic [6:0] SEG_2       = 7'h24;
    localparam logic [6:0] SEG_3       = 7'h30;
    localparam logic [6:0] SEG_4       = 7'h19;
    localparam logic [6:0] SEG_5       = 7'h12;
    localparam logic [6:0] SEG_6       = 7'h02;
    localparam logic [6:0] SEG_7       = 7'h78;
    localparam logic [6:0] SEG_8       = 7'h00;
    localparam logic [6:0] SEG_9       = 7'h10;
    localparam logic [6:0] SEG_TRACO   = 7'h3F;
    localparam logic [6:0] SEG_APAGADO = 7'h7F;

endpackage

// File: rtl/decod_7seg.sv
// BCD digit to active-low 7-segment decoder; 10..31 show a dash.
// Ports: digito (5-bit value in), segmentos (7-bit {g..a} out).
module decod_7seg
    import freq_pkg::*;
(
    input  logic [4:0] digito,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_TRACO;
        unique case (digito)
            5'd0:    segmentos = SEG_0;
            5'd1:    segmentos = SEG_1;
            5'd2:    segmentos = SEG_2;
            5'd3:    segmentos = SEG_3;
            5'd4:    segmentos = SEG_4;
            5'd5:    segmentos = SEG_5;
            5'd6:    segmentos = SEG_6;
            5'd7:    segmentos = SEG_7;
            5'd8:    segmentos = SEG_8;
            5'd9:    segmentos = SEG_9;
            default: segmentos = SEG_TRACO;
        endcase
    end

endmodule

// File: rtl/varredura_display.sv
// Five-digit multiplexed 7-segment scanner with shadow register,
// dark guard interval and leading-zero blanking.
// Ports: clk, limpar (sync reset), carregar (load strobe),
// reg_1..reg_5 (BCD digits), apagar_zeros (blank enable),
// anodos (active-low digit select), segmentos (active-low {g..a}).
module varredura_display
    import freq_pkg::*;
#(
    parameter int DIV_VARREDURA = 1000,
    parameter int GUARDA        = 2
) (
    input  logic       clk,
    input  logic       limpar,
    input  logic       carregar,
    input  logic [4:0] reg_1,
    input  logic [4:0] reg_2,
    input  logic [4:0] reg_3,
    input  logic [4:0] reg_4,
    input  logic [4:0] reg_5,
    input  logic       apagar_zeros,
    output logic [4:0] anodos,
    output logic [6:0] segmentos
);

    localparam int MAXC = (DIV_VARREDURA > GUARDA) ?
                          DIV_VARREDURA : GUARDA;
    localparam int PW   = $clog2(MAXC);

    logic [4:0]    sombra     [NUM_DIGITOS];
    logic [4:0]    nxt_sombra [NUM_DIGITOS];
    estado_t       estado, nxt_estado;
    logic [2:0]    idx, nxt_idx;
    logic [PW-1:0] presc, nxt_presc;

    logic [4:0]    digito;
    logic [6:0]    seg_dec;
    logic          apaga;
    logic [4:0]    nxt_anodos;
    logic [6:0]    nxt_seg;

    // Next-state logic; outputs are registered from these values so
    // they describe the same cycle as the state they accompany.
    always_comb begin
        nxt_sombra = sombra;
        if (carregar)
            nxt_sombra = '{reg_1, reg_2, reg_3, reg_4, reg_5};

        nxt_estado = estado;
        nxt_idx    = idx;
        nxt_presc  = presc + 1'b1;
        unique case (estado)
            APAGADO: begin
                if (presc == PW'(GUARDA - 1)) begin
                    nxt_estado = ATIVO;
                    nxt_presc  = '0;
                end
            end
            ATIVO: begin
                if (presc == PW'(DIV_VARREDURA - 1)) begin
                    nxt_estado = APAGADO;
                    nxt_presc  = '0;
                    nxt_idx    = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                end
            end
            default: nxt_estado = APAGADO;
        endcase
    end

    assign digito = nxt_sombra[nxt_idx];

    // Blank when this digit and all above it are zero; a dash is
    // non-zero, and the units digit always shows.
    always_comb begin
        apaga = apagar_zeros && (nxt_idx != 3'd0);
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (3'(i) >= nxt_idx && nxt_sombra[i] != 5'd0)
                apaga = 1'b0;
        end
    end

    decod_7seg u_decod (
        .digito    (digito),
        .segmentos (seg_dec)
    );

    always_comb begin
        nxt_anodos = 5'b11111;
        nxt_seg    = SEG_APAGADO;
        if (nxt_estado == ATIVO) begin
            nxt_anodos = ~(5'b00001 << nxt_idx);
            nxt_seg    = apaga ? SEG_APAGADO : seg_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (limpar) begin
            for (int i = 0; i < NUM_DIGITOS; i++)
                sombra[i] <= '0;
            estado    <= APAGADO;
            idx       <= '0;
            presc     <= '0;
            anodos    <= 5'b11111;
            segmentos <= SEG_APAGADO;
        end else begin
            sombra    <= nxt_sombra;
            estado    <= nxt_estado;
            idx       <= nxt_idx;
            presc     <= nxt_presc;
            anodos    <= nxt_anodos;
            segmentos <= nxt_seg;
        end
    end

endmodule

// File: tb/tb_varredura_display.sv
// Self-checking bench for varredura_display (DIV=4, GUARDA=1):
// directed scenarios plus random traffic against a frame-position model.
module tb_varredura_display;

    localparam int DIV   = 4;
    localparam int GRD   = 1;
    localparam int P     = DIV + GRD;
    localparam int FRAME = 5 * P;

    logic       clk = 1'b0;
    logic       limpar, carregar, apagar_zeros;
    logic [4:0] reg_1, reg_2, reg_3, reg_4, reg_5;
    logic [4:0] anodos;
    logic [6:0] segmentos;

    always #5 clk = ~clk;

    varredura_display #(
        .DIV_VARREDURA (DIV),
        .GUARDA        (GRD)
    ) dut (
        .clk          (clk),
        .limpar       (limpar),
        .carregar     (carregar),
        .reg_1        (reg_1),
        .reg_2        (reg_2),
        .reg_3        (reg_3),
        .reg_4        (reg_4),
        .reg_5        (reg_5),
        .apagar_zeros (apagar_zeros),
        .anodos       (anodos),
        .segmentos    (segmentos)
    );

    int tests = 0;
    int fails = 0;

    // Model: n = cycle number since the last reset edge (1 = first
    // dark cycle); ms = shadow digits; map = blanking enable seen.
    int         n;
    int         ms [5];
    bit         map;
    logic [4:0] d  [5];
    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] ex [5];
    logic [4:0] t_an [11] = '{5'h1F, 5'h1F, 5'h1E, 5'h1E, 5'h1E,
                              5'h1E, 5'h1F, 5'h1D, 5'h1D, 5'h1D,
                              5'h1D};

    function automatic int m_idx();
        int pos = (n - 1) % FRAME;
        if ((pos % P) < GRD)
            return -1;
        return pos / P;
    endfunction

    function automatic int m_within();
        return ((n - 1) % FRAME) % P;
    endfunction

    function automatic logic [4:0] m_an();
        int i = m_idx();
        if (i < 0)
            return 5'h1F;
        return ~(5'b00001 << i);
    endfunction

    function automatic logic [6:0] m_seg();
        int i = m_idx();
        bit z = 1'b1;
        if (i < 0)
            return 7'h7F;
        if (map && i != 0) begin
            for (int j = i; j < 5; j++)
                if (ms[j] != 0)
                    z = 1'b0;
            if (z)
                return 7'h7F;
        end
        if (ms[i] > 9)
            return 7'h3F;
        return tab[ms[i]];
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h n=%0d",
                   tag, got, exp, n);
        end
    endtask

    task automatic tick();
        reg_1 = d[0];
        reg_2 = d[1];
        reg_3 = d[2];
        reg_4 = d[3];
        reg_5 = d[4];
        @(posedge clk);
        if (limpar) begin
            for (int j = 0; j < 5; j++)
                ms[j] = 0;
            n = 1;
        end else begin
            if (carregar)
                for (int j = 0; j < 5; j++)
                    ms[j] = int'(d[j]);
            n++;
        end
        map = apagar_zeros;
        #1;
        chk("model_an", {3'b0, anodos}, {3'b0, m_an()});
        chk("model_seg", {1'b0, segmentos}, {1'b0, m_seg()});
    endtask

    task automatic load(input int a0, a1, a2, a3, a4,
                        input logic ap);
        d[0] = 5'(a0);
        d[1] = 5'(a1);
        d[2] = 5'(a2);
        d[3] = 5'(a3);
        d[4] = 5'(a4);
        apagar_zeros = ap;
        carregar = 1'b1;
        tick();
        carregar = 1'b0;
    endtask

    task automatic frame_const(input string tag);
        for (int c = 0; c < FRAME + 3; c++) begin
            tick();
            if (m_idx() >= 0)
                chk(tag, {1'b0, segmentos}, {1'b0, ex[m_idx()]});
        end
    endtask

    initial begin
        int guard;
        n = 1;
        map = 1'b0;
        for (int j = 0; j < 5; j++) begin
            ms[j] = 0;
            d[j]  = '0;
        end
        limpar = 1'b1;
        carregar = 1'b1;
        apagar_zeros = 1'b0;
        d[0] = 5'd9;
        tick();
        carregar = 1'b0;
        d[0] = 5'd0;
        tick();
        chk("reset_an", {3'b0, anodos}, 8'h1F);
        chk("reset_seg", {1'b0, segmentos}, 8'h7F);

        // Reset release timing
        limpar = 1'b0;
        chk("timing_c1", {3'b0, anodos}, {3'b0, t_an[1]});
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk("timing", {3'b0, anodos}, {3'b0, t_an[c]});
        end
        for (int c = 11; c <= 26; c++)
            tick();
        chk("frame_c26", {3'b0, anodos}, 8'h1F);
        tick();
        chk("frame_c27", {3'b0, anodos}, 8'h1E);

        // Leading-zero blanking on / off
        load(3, 0, 7, 0, 0, 1'b1);
        ex = '{7'h30, 7'h40, 7'h78, 7'h7F, 7'h7F};
        frame_const("blank_on");
        apagar_zeros = 1'b0;
        ex = '{7'h30, 7'h40, 7'h78, 7'h40, 7'h40};
        frame_const("blank_off");

        // All zeros
        load(0, 0, 0, 0, 0, 1'b1);
        ex = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        frame_const("all_zero");

        // Invalid digit is a dash and counts as non-zero
        load(0, 0, 12, 0, 0, 1'b1);
        ex = '{7'h40, 7'h40, 7'h3F, 7'h7F, 7'h7F};
        frame_const("dash");

        // Reset in the third active cycle of index 2
        load(1, 2, 3, 4, 5, 1'b0);
        guard = 0;
        while (!(m_idx() == 2 && m_within() == GRD + 2)
               && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        chk("mid_found", 8'(m_idx()), 8'd2);
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        chk("mid_an", {3'b0, anodos}, 8'h1F);
        chk("mid_seg", {1'b0, segmentos}, 8'h7F);
        tick();
        chk("mid_restart_an", {3'b0, anodos}, 8'h1E);
        chk("mid_restart_seg", {1'b0, segmentos}, 8'h40);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (m_idx() >= 0)
                chk("mid_shadow0", {1'b0, segmentos}, 8'h40);
        end

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            limpar   = ($urandom_range(0, 149) == 0);
            carregar = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0)
                apagar_zeros = ~apagar_zeros;
            if (carregar)
                for (int j = 0; j < 5; j++)
                    d[j] = ($urandom_range(0, 1) == 0) ? 5'd0 :
                           ($urandom_range(0, 7) == 0) ?
                           5'($urandom_range(10, 31)) :
                           5'($urandom_range(0, 9));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
